alu_req_arbiter: RTL
====================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one combinational ALU (opcodes 0x01-0x09) between two requesters, A and B.
//  Each request carries an opcode and two operands. The block arbitrates round-robin,
//  registers the granted operation onto the ALU inputs and captures the ALU result.
//  It returns the result with a tagged valid/ready response.
//  Sits between the control/test sequencers and the ALU instance.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; matches ALU data width
//  OPRN_WIDTH   6  opcode width; matches ALU opcode width
//  OPRN_MAX     9  highest legal opcode; legal range 1..OPRN_MAX
// PORTS
//  CLK        in   1           clock; all state changes on posedge
//  RST        in   1           asynchronous, active-low reset
//  a_valid    in   1           requester A has an operation pending
//  a_ready    out  1           A request accepted this cycle (a_valid & a_ready)
//  a_oprn     in   OPRN_WIDTH  A opcode
//  a_op1      in   DATA_WIDTH  A operand 1
//  a_op2      in   DATA_WIDTH  A operand 2
//  b_valid, b_ready, b_oprn, b_op1, b_op2   same as A, for requester B
//  alu_oprn   out  OPRN_WIDTH  registered opcode to the ALU
//  alu_op1    out  DATA_WIDTH  registered operand 1 to the ALU
//  alu_op2    out  DATA_WIDTH  registered operand 2 to the ALU
//  alu_result in   DATA_WIDTH  combinational ALU result
//  rsp_valid  out  1           response available
//  rsp_ready  in   1           consumer takes the response (rsp_valid & rsp_ready)
//  rsp_id     out  1           0 = response for A, 1 = response for B
//  rsp_data   out  DATA_WIDTH  captured result
//  rsp_err    out  1           opcode was illegal (0 or > OPRN_MAX)
//  busy       out  1           state != IDLE
// BEHAVIOUR
//  Reset (RST low, async)
//   - state = IDLE; all outputs 0; last_grant = B, so A wins the first tie.
//   - Any in-flight or pending response is discarded.
//  FSM: IDLE -> EXEC -> RESP -> IDLE
//   IDLE
//    - grant = A if only a_valid; B if only b_valid.
//    - If both are valid, grant the requester that is not last_grant.
//    - a_ready/b_ready are combinational and high only in IDLE, for the granted side.
//      At most one is high in any cycle.
//    - On accept: latch oprn/op1/op2 into the alu_* registers, latch the id,
//      update last_grant, go to EXEC.
//   EXEC (one cycle, lets the ALU settle)
//    - Capture alu_result into rsp_data.
//    - Illegal opcode: rsp_data = 0 and rsp_err = 1; otherwise rsp_err = 0.
//    - Set rsp_valid = 1, go to RESP.
//   RESP
//    - Hold rsp_valid, rsp_id, rsp_data, rsp_err stable until rsp_ready.
//    - On handshake: rsp_valid = 0, go to IDLE.
//    - The next grant is not possible before the following cycle (no bypass).
//  Timing
//   - Accept edge N: alu_* valid after N. rsp_valid high after N+1.
//   - Minimum issue interval is 3 cycles.
//  Other rules
//   - alu_* registers hold their last values after an operation; they are not cleared.
//   - Requesters must hold valid and fields stable until ready.
//     A requester dropping valid before grant is legal and is simply not granted.
//   - A request is never lost or duplicated.
//     Under continuous contention, grants strictly alternate A, B, A, B.
// TESTING
//  1. A only: opcode 0x01, 15 + 3
//     -> a_ready 1 cycle; rsp_valid 2 edges later; rsp_id=0, rsp_data=18, rsp_err=0.
//  2. A (0x02, 15, 5) and B (0x03, 15, 5) asserted together after reset
//     -> A first (rsp 10, id 0), then B (rsp 75, id 1).
//  3. Both valid continuously for 4 ops -> grant order A, B, A, B;
//     a_ready and b_ready never high together.
//  4. rsp_ready held low 3 cycles during RESP
//     -> rsp_* stable, busy=1, a_ready=b_ready=0; released in the cycle after rsp_ready.
//  5. Opcode 0x0A -> rsp_err=1, rsp_data=0.
//     Opcode 0x09 with 15 < 2 -> rsp_data=0, rsp_err=0.
//     Opcode 0x08 with 15, 2 -> rsp_data=32'hFFFFFFF0.
//  6. RST low asynchronously during EXEC -> all outputs 0 immediately; no response emitted.
//     After release, simultaneous A/B requests grant A first.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between requesters A and B.
// Granted operations are registered onto the ALU inputs; results return on a tagged valid/ready response.
module alu_req_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6,
  parameter int OPRN_MAX   = 9
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [OPRN_WIDTH-1:0] a_oprn,
  input  logic [DATA_WIDTH-1:0] a_op1,
  input  logic [DATA_WIDTH-1:0] a_op2,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [OPRN_WIDTH-1:0] b_oprn,
  input  logic [DATA_WIDTH-1:0] b_op1,
  input  logic [DATA_WIDTH-1:0] b_op2,
  output logic [OPRN_WIDTH-1:0] alu_oprn,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);

  // state | meaning
  // IDLE  | no operation in flight; ready offered to the granted requester
  // EXEC  | operands on the ALU inputs, result settling
  // RESP  | response presented and held until rsp_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [OPRN_WIDTH-1:0] OPRN_MAX_V = OPRN_WIDTH'(OPRN_MAX);

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  run_q, run_d;
  logic [OPRN_WIDTH-1:0] alu_oprn_q, alu_oprn_d;
  logic [DATA_WIDTH-1:0] alu_op1_q, alu_op1_d;
  logic [DATA_WIDTH-1:0] alu_op2_q, alu_op2_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  grant_a, grant_b;
  logic                  oprn_illegal;

  // run_q keeps ready low while reset is asserted and for the first edge after release.
  always_comb begin
    grant_a      = a_valid & (~b_valid | last_grant_q);
    grant_b      = b_valid & (~a_valid | ~last_grant_q);
    oprn_illegal = (alu_oprn_q == '0) || (alu_oprn_q > OPRN_MAX_V);
  end

  assign a_ready   = run_q & (state_q == IDLE) & grant_a;
  assign b_ready   = run_q & (state_q == IDLE) & grant_b;
  assign alu_oprn  = alu_oprn_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    run_d        = 1'b1;
    alu_oprn_d   = alu_oprn_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (a_ready | b_ready) begin
          alu_oprn_d   = b_ready ? b_oprn : a_oprn;
          alu_op1_d    = b_ready ? b_op1  : a_op1;
          alu_op2_d    = b_ready ? b_op2  : a_op2;
          rsp_id_d     = b_ready;
          last_grant_d = b_ready;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = oprn_illegal ? '0 : alu_result;
        rsp_err_d   = oprn_illegal;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      run_q        <= 1'b0;
      alu_oprn_q   <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      run_q        <= run_d;
      alu_oprn_q   <= alu_oprn_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule
